// File: rtl/rcvr_framed.sv
// rcvr_framed: serial header hunter plus payload capture, feeding a show-ahead word FIFO.
// Header bits and payload bits arrive MSB first, one per clock; payload words are never scanned for headers.
module rcvr_framed #(
    parameter int unsigned       HDR_W  = 8,
    parameter logic [HDR_W-1:0]  HDR    = HDR_W'(8'hA5),
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       DEPTH  = 2,
    parameter int unsigned       CNT_W  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         data_in,
    input  logic                         reading,
    output logic                         ready,
    output logic [DATA_W-1:0]            data_out,
    output logic                         overrun,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]             drop_cnt,
    output logic                         in_body
);

    localparam int unsigned FILL_W = $clog2(HDR_W + 1);
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MEM_N  = 1 << PTR_W;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

    typedef enum logic {
        S_HUNT = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [HDR_W-1:0]      r_shreg;
    logic [HDR_W-1:0]      w_shreg_nxt;
    logic [FILL_W-1:0]     r_fill;
    logic [FILL_W-1:0]     w_fill_nxt;
    logic [DATA_W-1:0]     r_body;
    logic [DATA_W-1:0]     w_body_nxt;
    logic [BIT_W-1:0]      r_bitcnt;
    logic [BIT_W-1:0]      w_bitcnt_nxt;
    logic                  w_push;
    logic [HDR_W-1:0]      w_shift;
    logic [DATA_W-1:0]     w_word;

    logic [DATA_W-1:0]     r_mem [MEM_N];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W-1:0]      w_wptr_nxt;
    logic [PTR_W-1:0]      w_rptr_nxt;
    logic [LVL_W-1:0]      r_level;
    logic [LVL_W-1:0]      w_level_nxt;
    logic                  r_ready;
    logic [DATA_W-1:0]     r_dout;
    logic                  r_overrun;
    logic [CNT_W-1:0]      r_drop_cnt;
    logic                  r_in_body;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_drop;

    // Candidate header window and completed payload word including the bit on the line now.
    assign w_shift = HDR_W'({r_shreg, data_in});
    assign w_word  = DATA_W'({r_body, data_in});

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_HUNT;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: hunt for the header, then collect exactly DATA_W payload bits.
    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_fill_nxt   = r_fill;
        w_body_nxt   = r_body;
        w_bitcnt_nxt = r_bitcnt;
        w_push       = 1'b0;
        case (r_state)
            S_HUNT: begin
                w_shreg_nxt = w_shift;
                if (r_fill != FILL_W'(HDR_W)) w_fill_nxt = FILL_W'(r_fill + 1'b1);
                // The fill count keeps cleared leading zeros from matching.
                if ((r_fill >= FILL_W'(HDR_W - 1)) && (w_shift == HDR)) begin
                    w_state_nxt  = S_BODY;
                    w_bitcnt_nxt = '0;
                end
            end
            S_BODY: begin
                w_body_nxt   = w_word;
                w_bitcnt_nxt = BIT_W'(r_bitcnt + 1'b1);
                if (r_bitcnt == BIT_W'(DATA_W - 1)) begin
                    w_push       = 1'b1;
                    w_state_nxt  = S_HUNT;
                    w_shreg_nxt  = '0;
                    w_fill_nxt   = '0;
                    w_bitcnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    // Framer datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shreg   <= '0;
            r_fill    <= '0;
            r_body    <= '0;
            r_bitcnt  <= '0;
            r_in_body <= 1'b0;
        end else begin
            r_shreg   <= w_shreg_nxt;
            r_fill    <= w_fill_nxt;
            r_body    <= w_body_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_in_body <= (w_state_nxt == S_BODY);
        end
    end

    // FIFO control: a pop in the same cycle frees a slot for a push into a full FIFO.
    always_comb begin
        w_full      = (r_level == LVL_W'(DEPTH));
        w_pop       = reading & r_ready;
        w_push_ok   = w_push & (~w_full | w_pop);
        w_drop      = w_push & w_full & ~w_pop;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_level_nxt = r_level;
        if (w_push_ok)
            w_wptr_nxt = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(r_wptr + 1'b1);
        if (w_pop)
            w_rptr_nxt = (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(r_rptr + 1'b1);
        if (w_push_ok && !w_pop)
            w_level_nxt = LVL_W'(r_level + 1'b1);
        else if (w_pop && !w_push_ok)
            w_level_nxt = LVL_W'(r_level - 1'b1);
    end

    // FIFO storage, pointers, registered head word and status.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_N); i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ready <= 1'b0;
            r_dout  <= '0;
        end else begin
            if (w_push_ok) r_mem[r_wptr] <= w_word;
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != '0);
            // The word being written this cycle becomes the head when it lands in the head slot.
            r_dout  <= (w_push_ok && (w_rptr_nxt == r_wptr)) ? w_word : r_mem[w_rptr_nxt];
        end
    end

    // Sticky overrun and saturating drop counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop)       r_overrun <= 1'b1;
            else if (reading) r_overrun <= 1'b0;
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}}))
                r_drop_cnt <= CNT_W'(r_drop_cnt + 1'b1);
        end
    end

    assign ready    = r_ready;
    assign data_out = r_dout;
    assign overrun  = r_overrun;
    assign level    = r_level;
    assign drop_cnt = r_drop_cnt;
    assign in_body  = r_in_body;

endmodule

// File: tb/tb_rcvr_framed.sv
// tb_rcvr_framed: directed frames against three configurations of rcvr_framed.
module tb_rcvr_framed;

    logic clk = 1'b0;
    logic din = 1'b0;
    logic rd  = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Default configuration.
    logic        a_ready, a_overrun, a_in_body;
    logic [7:0]  a_dout, a_drop;
    logic [1:0]  a_level;
    // Short header, 12-bit payload.
    logic        b_ready, b_overrun, b_in_body;
    logic [11:0] b_dout;
    logic [7:0]  b_drop;
    logic [1:0]  b_level;
    // Single-entry FIFO, 2-bit drop counter.
    logic        c_ready, c_overrun, c_in_body;
    logic [7:0]  c_dout;
    logic [1:0]  c_drop;
    logic [0:0]  c_level;

    rcvr_framed u_a (
        .clock(clk), .reset(rst_a), .data_in(din), .reading(rd),
        .ready(a_ready), .data_out(a_dout), .overrun(a_overrun),
        .level(a_level), .drop_cnt(a_drop), .in_body(a_in_body)
    );

    rcvr_framed #(.HDR_W(4), .HDR(4'b1101), .DATA_W(12)) u_b (
        .clock(clk), .reset(rst_b), .data_in(din), .reading(rd),
        .ready(b_ready), .data_out(b_dout), .overrun(b_overrun),
        .level(b_level), .drop_cnt(b_drop), .in_body(b_in_body)
    );

    rcvr_framed #(.DEPTH(1), .CNT_W(2)) u_c (
        .clock(clk), .reset(rst_c), .data_in(din), .reading(rd),
        .ready(c_ready), .data_out(c_dout), .overrun(c_overrun),
        .level(c_level), .drop_cnt(c_drop), .in_body(c_in_body)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n bits of v, MSB first, one per clock.
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = v[i];
            tick();
        end
    endtask

    task automatic frame_a(input logic [7:0] pay);
        send_bits(32'hA5, 8);
        send_bits(32'(pay), 8);
    endtask

    task automatic restart_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    initial begin
        logic saw_body;
        tick();
        tick();
        chk("a_rst_ready",   32'(a_ready),   32'd0);
        chk("a_rst_level",   32'(a_level),   32'd0);
        chk("a_rst_overrun", 32'(a_overrun), 32'd0);
        chk("a_rst_drop",    32'(a_drop),    32'd0);
        chk("a_rst_in_body", 32'(a_in_body), 32'd0);
        rst_a = 1'b0;

        // Basic frame A5 + 3C.
        send_bits(32'hA5, 8);
        chk("a_in_body_after_hdr", 32'(a_in_body), 32'd1);
        send_bits(32'h3C, 8);
        chk("a_basic_ready",   32'(a_ready),   32'd1);
        chk("a_basic_dout",    32'(a_dout),    32'h3C);
        chk("a_basic_level",   32'(a_level),   32'd1);
        chk("a_basic_overrun", 32'(a_overrun), 32'd0);
        chk("a_basic_in_body", 32'(a_in_body), 32'd0);

        // Zeros never match; then an overlapped header.
        restart_a();
        saw_body = 1'b0;
        din = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_in_body) saw_body = 1'b1;
        end
        chk("a_zeros_no_hdr", 32'(saw_body), 32'd0);
        send_bits(32'b1010100101, 10);
        chk("a_overlap_in_body", 32'(a_in_body), 32'd1);
        send_bits(32'hFF, 8);
        chk("a_overlap_ready", 32'(a_ready), 32'd1);
        chk("a_overlap_dout",  32'(a_dout),  32'hFF);

        // Three frames into a two-deep FIFO with no reader.
        restart_a();
        frame_a(8'h11);
        frame_a(8'h22);
        frame_a(8'h33);
        chk("a_full_level",   32'(a_level),   32'd2);
        chk("a_full_dout",    32'(a_dout),    32'h11);
        chk("a_full_overrun", 32'(a_overrun), 32'd1);
        chk("a_full_drop",    32'(a_drop),    32'd1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("a_pop_dout",    32'(a_dout),    32'h22);
        chk("a_pop_level",   32'(a_level),   32'd1);
        chk("a_pop_overrun", 32'(a_overrun), 32'd0);

        // Pop coincident with the last payload bit into a full FIFO.
        restart_a();
        frame_a(8'h11);
        frame_a(8'h22);
        send_bits(32'hA5, 8);
        send_bits(32'h19, 7);
        rd = 1'b1;
        send_bits(32'h1, 1);
        rd = 1'b0;
        chk("a_coinc_level",   32'(a_level),   32'd2);
        chk("a_coinc_overrun", 32'(a_overrun), 32'd0);
        chk("a_coinc_drop",    32'(a_drop),    32'd0);
        chk("a_coinc_dout",    32'(a_dout),    32'h22);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("a_coinc_next_dout",  32'(a_dout),  32'h33);
        chk("a_coinc_next_level", 32'(a_level), 32'd1);

        // Short header, 12-bit payload, async reset mid-payload.
        rst_a = 1'b1;
        rst_b = 1'b0;
        send_bits(32'hD, 4);
        send_bits(32'hABC, 12);
        chk("b_dout",  32'(b_dout),  32'hABC);
        chk("b_ready", 32'(b_ready), 32'd1);
        send_bits(32'hD, 4);
        chk("b_in_body", 32'(b_in_body), 32'd1);
        send_bits(32'h123 >> 6, 6);
        rst_b = 1'b1;
        #1;
        chk("b_async_ready",   32'(b_ready),   32'd0);
        chk("b_async_in_body", 32'(b_in_body), 32'd0);
        chk("b_async_level",   32'(b_level),   32'd0);
        tick();
        rst_b = 1'b0;
        send_bits(32'hD, 4);
        send_bits(32'h001, 12);
        chk("b_after_rst_dout",  32'(b_dout),  32'h001);
        chk("b_after_rst_level", 32'(b_level), 32'd1);

        // Depth 1 with reader held high: one-cycle ready pulse per frame.
        rst_b = 1'b1;
        rst_c = 1'b0;
        rd = 1'b1;
        for (int f = 0; f < 2; f++) begin
            send_bits(32'hA5, 8);
            send_bits(32'h5A, 8);
            chk("c_pulse_ready", 32'(c_ready), 32'd1);
            chk("c_pulse_dout",  32'(c_dout),  32'h5A);
            tick();
            chk("c_pulse_ready_low", 32'(c_ready),   32'd0);
            chk("c_pulse_overrun",   32'(c_overrun), 32'd0);
        end
        rd = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            send_bits(32'hA5, 8);
            send_bits(32'(f), 8);
        end
        chk("c_sat_drop",    32'(c_drop),    32'd3);
        chk("c_sat_overrun", 32'(c_overrun), 32'd1);
        chk("c_sat_level",   32'(c_level),   32'd1);
        chk("c_sat_dout",    32'(c_dout),    32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
